instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Parametrised, loadable instruction memory for the processor's fetch stage. A streaming load port fills the array at run time instead of using a fixed boot image. A registered fetch port then returns one instruction per cycle with a valid strobe. Out-of-image fetches return a configurable NOP and flag an address error. The block sits between the program loader / testbench and the PC/decode logic.

## Interface
- DATA_W, 8, instruction width in bits
- ADDR_W, 8, PC / address width
- DEPTH, 16, number of instruction words; must satisfy DEPTH ≤ 2^ADDR_W
- NOP_CODE, 8'h00, value returned on invalid fetches (DATA_W bits)

- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- load_start  in  1  one-cycle pulse; begins a new image load at address 0
- ld_valid  in  1  load beat present
- ld_data  in  DATA_W  load beat payload
- ld_last  in  1  marks final beat of image (sampled with ld_valid)
- ld_ready  out  1  block accepts a load beat this cycle
- fetch_req  in  1  fetch request
- pc  in  ADDR_W  fetch address
- instr_valid  out  1  instr_code valid this cycle
- instr_code  out  DATA_W  fetched instruction
- addr_err  out  1  current instr_code is NOP_CODE due to pc ≥ image_len
- busy  out  1  load in progress; core must stall
- loaded  out  1  a complete image is present
- load_ovf  out  1  last load was truncated at DEPTH words
- image_len  out  ADDR_W+1  number of valid words in the image

## Operation
- States: EMPTY (after reset), LOAD, READY.
- Reset (async, any state) forces the following:
  - state EMPTY, wr_ptr=0.
  - All outputs 0: instr_valid, instr_code, addr_err, busy, loaded, load_ovf, image_len, ld_ready.
  - Memory array contents are not cleared.
- EMPTY:
  - fetch_req is ignored (instr_valid stays 0).
  - load_start → LOAD.
- LOAD:
  - ld_ready=1 and busy=1.
  - Each cycle with ld_valid&ld_ready writes Mem[wr_ptr]=ld_data, then increments wr_ptr.
  - A beat with ld_last → READY, with image_len=wr_ptr+1, loaded=1, load_ovf=0.
  - An accepted beat at wr_ptr=DEPTH-1 without ld_last → READY, with image_len=DEPTH, loaded=1, load_ovf=1.
  - load_start during LOAD restarts the load: wr_ptr=0; a beat in the same cycle is dropped.
  - fetch_req is ignored.
- READY:
  - fetch_req registers the read. On the next cycle instr_valid=1 and one of:
    - pc < image_len: instr_code=Mem[pc], addr_err=0.
    - otherwise: instr_code=NOP_CODE, addr_err=1.
  - No fetch_req → instr_valid=0 and addr_err=0; instr_code holds its last value.
  - load_start → LOAD, with wr_ptr=0, image_len=0, loaded=0, load_ovf=0.
- Simultaneous load_start and fetch_req in READY: load_start wins and the fetch is dropped (no instr_valid).
- pc compare is unsigned, zero-extended to ADDR_W+1 bits.

## Timing
- Fetch latency is 1 cycle: fetch_req at edge N → instr_valid/instr_code after edge N+1.
- Fetch throughput is one per cycle; back-to-back requests are fully pipelined.
- Load throughput is one beat per cycle while ld_ready=1.
- ld_ready, busy and loaded are registered state outputs, with no combinational input-to-output paths.
- Load completion timing:
  - busy falls on the edge that accepts the last or overflow beat.
  - The first fetch may be issued in the following cycle.
- A write followed by a read of the same address on the next cycle returns the new data.
- Reset mid-load or mid-fetch clears outputs immediately, without waiting for clk. Load resumes only after a fresh load_start.

## Test plan
- Reset, then load_start, then stream 13,51,0A,C5,4B,3C with ld_last on the 6th beat → image_len=6, loaded=1, busy=0. Fetch pc 0..5 back-to-back → same codes in order, each one cycle later with instr_valid=1.
- In READY, fetch pc=6 and pc=FF → instr_code=00, addr_err=1, instr_valid=1 for each. Then pc=2 → 0A, addr_err=0.
- With DEPTH=16, stream 17 beats without ld_last → READY after beat 16, load_ovf=1, image_len=16, ld_ready=0, beat 17 not accepted.
- fetch_req in EMPTY and during LOAD → instr_valid never asserts, memory unchanged.
- Assert reset after 3 load beats, mid-cycle → all outputs 0 immediately, state EMPTY. A new load of 2 words gives image_len=2.
- In READY, assert load_start and fetch_req in the same cycle → no instr_valid next cycle; busy=1, loaded=0, image_len=0.

Source files
------------

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Brief    : Run-time loadable instruction memory with a registered fetch port.
// Revision : 1.0
// ============================================================================
module instr_mem_loader #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] NOP_CODE = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_start_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_code_o,
    output logic              addr_err_o,
    output logic              busy_o,
    output logic              loaded_o,
    output logic              load_ovf_o,
    output logic [ADDR_W:0]   image_len_o
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]  DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  ONE_LEN   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     image_len_q, image_len_d;
    logic                loaded_q, loaded_d;
    logic                load_ovf_q, load_ovf_d;
    logic                busy_q, busy_d;
    logic                ld_ready_q, ld_ready_d;
    logic                instr_valid_q, instr_valid_d;
    logic                addr_err_q, addr_err_d;
    logic [DATA_W-1:0]   instr_code_q, instr_code_d;

    logic                wr_en;
    logic [DATA_W-1:0]   rd_data;
    logic                pc_in_image;

    // Array is deliberately not reset so a reset does not cost a reload cycle per word.
    logic [DATA_W-1:0]   mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= ld_data_i;
        end
    end

    // pc beyond the image is never used to index the array, so truncation is safe.
    assign rd_data     = mem_q[pc_i[IDX_W-1:0]];
    assign pc_in_image = ({1'b0, pc_i} < image_len_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_EMPTY;
            wr_ptr_q      <= '0;
            image_len_q   <= '0;
            loaded_q      <= 1'b0;
            load_ovf_q    <= 1'b0;
            busy_q        <= 1'b0;
            ld_ready_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            instr_code_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            image_len_q   <= image_len_d;
            loaded_q      <= loaded_d;
            load_ovf_q    <= load_ovf_d;
            busy_q        <= busy_d;
            ld_ready_q    <= ld_ready_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
            instr_code_q  <= instr_code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        image_len_d   = image_len_q;
        loaded_d      = loaded_q;
        load_ovf_d    = load_ovf_q;
        instr_valid_d = 1'b0;
        addr_err_d    = 1'b0;
        instr_code_d  = instr_code_q;
        wr_en         = 1'b0;

        case (state_q)
            S_EMPTY: begin
                if (load_start_i) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                end
            end
            S_LOAD: begin
                // A restart takes priority and drops any beat presented with it.
                if (load_start_i) begin
                    wr_ptr_d = '0;
                end else if (ld_valid_i) begin
                    wr_en = 1'b1;
                    if (ld_last_i) begin
                        state_d     = S_READY;
                        image_len_d = (ADDR_W + 1)'(wr_ptr_q) + ONE_LEN;
                        loaded_d    = 1'b1;
                        load_ovf_d  = 1'b0;
                    end else if (wr_ptr_q == LAST_IDX) begin
                        state_d     = S_READY;
                        image_len_d = DEPTH_LEN;
                        loaded_d    = 1'b1;
                        load_ovf_d  = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            S_READY: begin
                if (load_start_i) begin
                    state_d     = S_LOAD;
                    wr_ptr_d    = '0;
                    image_len_d = '0;
                    loaded_d    = 1'b0;
                    load_ovf_d  = 1'b0;
                end else if (fetch_req_i) begin
                    instr_valid_d = 1'b1;
                    if (pc_in_image) begin
                        instr_code_d = rd_data;
                    end else begin
                        instr_code_d = NOP_CODE;
                        addr_err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        busy_d     = (state_d == S_LOAD);
        ld_ready_d = (state_d == S_LOAD);
    end

    assign ld_ready_o    = ld_ready_q;
    assign busy_o        = busy_q;
    assign loaded_o      = loaded_q;
    assign load_ovf_o    = load_ovf_q;
    assign image_len_o   = image_len_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_code_o  = instr_code_q;
    assign addr_err_o    = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Brief    : Directed bench for instr_mem_loader with a fetch-result scoreboard.
// Revision : 1.0
// ============================================================================
module tb_instr_mem_loader;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              ld_ready, instr_valid, addr_err, busy, loaded, load_ovf;
    logic [DATA_W-1:0] instr_code;
    logic [ADDR_W:0]   image_len;

    instr_mem_loader #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .NOP_CODE(8'h00)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_start_i (load_start),
        .ld_valid_i   (ld_valid),
        .ld_data_i    (ld_data),
        .ld_last_i    (ld_last),
        .ld_ready_o   (ld_ready),
        .fetch_req_i  (fetch_req),
        .pc_i         (pc),
        .instr_valid_o(instr_valid),
        .instr_code_o (instr_code),
        .addr_err_o   (addr_err),
        .busy_o       (busy),
        .loaded_o     (loaded),
        .load_ovf_o   (load_ovf),
        .image_len_o  (image_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] code;
        logic              err;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mem_m [DEPTH];
    int                len_m = 0;
    bit                pend = 1'b0;
    int                passed = 0;
    int                total = 0;
    int                fails = 0;
    logic [DATA_W-1:0] img [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; a fetch accepted on this edge must show up right after it.
    task automatic tick();
        bit   exp_v;
        exp_t e;
        exp_v = pend;
        pend  = 1'b0;
        @(posedge clk);
        #1;
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_v});
        if (exp_v && sb.size() > 0) begin
            e = sb.pop_front();
            if (instr_valid) begin
                chk("instr_code", {24'd0, instr_code}, {24'd0, e.code});
                chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
            end
        end
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] a);
        exp_t e;
        fetch_req = 1'b1;
        pc        = a;
        if (int'(a) < len_m) begin
            e.code = mem_m[a[3:0]];
            e.err  = 1'b0;
        end else begin
            e.code = 8'h00;
            e.err  = 1'b1;
        end
        sb.push_back(e);
        pend = 1'b1;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_code"}, {24'd0, instr_code}, 32'd0);
        chk({tag, "_err"}, {31'd0, addr_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_loaded"}, {31'd0, loaded}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, load_ovf}, 32'd0);
        chk({tag, "_len"}, {23'd0, image_len}, 32'd0);
        chk({tag, "_ready"}, {31'd0, ld_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        img[0] = 8'h13; img[1] = 8'h51; img[2] = 8'h0A;
        img[3] = 8'hC5; img[4] = 8'h4B; img[5] = 8'h3C;

        #1 reset = 1'b1;
        #1 chk_all_zero("reset");
        tick();
        tick();
        @(negedge clk) reset = 1'b0;
        tick();

        // Fetches in EMPTY are ignored
        fetch_req = 1'b1; pc = 8'd0;
        tick();
        tick();
        fetch_req = 1'b0;

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_ready", {31'd0, ld_ready}, 32'd1);

        // Fetches during LOAD are ignored
        fetch_req = 1'b1; pc = 8'd3;
        for (int i = 0; i < 6; i++) begin
            mem_m[i] = img[i];
            beat(img[i], i == 5);
        end
        ld_valid = 1'b0; ld_last = 1'b0; fetch_req = 1'b0;
        len_m = 6;
        chk("img_len", {23'd0, image_len}, 32'd6);
        chk("img_loaded", {31'd0, loaded}, 32'd1);
        chk("img_busy", {31'd0, busy}, 32'd0);
        chk("img_ready", {31'd0, ld_ready}, 32'd0);
        chk("img_ovf", {31'd0, load_ovf}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_fetch(8'(i));
            tick();
        end
        fetch_req = 1'b0;
        tick();
        chk("hold_code", {24'd0, instr_code}, 32'h3C);
        chk("hold_err", {31'd0, addr_err}, 32'd0);

        do_fetch(8'd6);  tick();
        do_fetch(8'hFF); tick();
        do_fetch(8'd2);  tick();
        fetch_req = 1'b0;
        tick();

        // load_start beats a simultaneous fetch
        load_start = 1'b1; fetch_req = 1'b1; pc = 8'd1;
        tick();
        load_start = 1'b0; fetch_req = 1'b0;
        len_m = 0;
        chk("race_busy", {31'd0, busy}, 32'd1);
        chk("race_loaded", {31'd0, loaded}, 32'd0);
        chk("race_len", {23'd0, image_len}, 32'd0);

        // Restart mid-load, then overflow
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b0);
        load_start = 1'b1; ld_data = 8'hCC;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < DEPTH) mem_m[i] = 8'(8'h80 + i * 7);
            beat(8'(8'h80 + i * 7), 1'b0);
            if (i == DEPTH - 1) begin
                chk("ovf_ready", {31'd0, ld_ready}, 32'd0);
                chk("ovf_busy", {31'd0, busy}, 32'd0);
                chk("ovf_flag", {31'd0, load_ovf}, 32'd1);
                chk("ovf_len", {23'd0, image_len}, 32'd16);
                chk("ovf_loaded", {31'd0, loaded}, 32'd1);
            end
        end
        ld_valid = 1'b0;
        chk("ovf_len_after17", {23'd0, image_len}, 32'd16);
        len_m = DEPTH;
        for (int i = 0; i <= DEPTH; i++) begin
            do_fetch(8'(i));
            tick();
        end
        do_fetch(8'd5);
        tick();
        fetch_req = 1'b0;
        tick();

        // Asynchronous reset partway through a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        beat(8'h11, 1'b0); mem_m[0] = 8'h11;
        beat(8'h22, 1'b0); mem_m[1] = 8'h22;
        beat(8'h33, 1'b0); mem_m[2] = 8'h33;
        ld_valid = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #3 reset = 1'b1;
        #1 chk_all_zero("async_rst");
        #2 reset = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h77;
        tick();
        ld_valid = 1'b0;
        chk("post_rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        mem_m[0] = 8'h5A; beat(8'h5A, 1'b0);
        mem_m[1] = 8'hA5; beat(8'hA5, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0;
        len_m = 2;
        chk("reload_len", {23'd0, image_len}, 32'd2);
        chk("reload_loaded", {31'd0, loaded}, 32'd1);
        chk("reload_ovf", {31'd0, load_ovf}, 32'd0);
        do_fetch(8'd0); tick();
        do_fetch(8'd1); tick();
        do_fetch(8'd2); tick();
        fetch_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
